ctr_obs_checker: RTL and testbench
==================================

CTR_OBS_CHECKER -- requirements
Module: ctr_obs_checker

Interface
REQ-001 Parameter OBS_W, default 128: width of one packed contract observation.
REQ-002 Parameter DEPTH, default 8: per-trace observation FIFO depth; power of two, >= 2.
REQ-003 Parameter CNT_W, default 32: width of the comparison counter and failure index.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 retire_1_i  in  1  trace-1 retirement strobe; pushes obs_1_i.
REQ-007 obs_1_i  in  OBS_W  trace-1 observation for the retiring instruction.
REQ-008 retire_2_i  in  1  trace-2 retirement strobe; pushes obs_2_i.
REQ-009 obs_2_i  in  OBS_W  trace-2 observation.
REQ-010 mask_i  in  OBS_W  contract field select; 1 = bit observed.
REQ-011 clear_i  in  1  synchronous restart.
REQ-012 ctr_equiv_o  out  1  sticky: all compared pairs equal, no overflow.
REQ-013 mismatch_o  out  1  one-cycle pulse on first mismatching pair.
REQ-014 overflow_o  out  1  sticky FIFO overflow flag.
REQ-015 fail_idx_o  out  CNT_W  index of first mismatching pair, 0-based.
REQ-016 cmp_cnt_o  out  CNT_W  number of pairs compared.
REQ-017 pending_o  out  1  either FIFO non-empty.

Function
REQ-018 On retire_k_i, (obs_k_i & mask_i) SHALL be written into FIFO k at that edge; mask is sampled at push, not at compare.
REQ-019 Traces retire independently; no alignment between retire_1_i and retire_2_i is required.
REQ-020 In RUN, when both FIFOs are non-empty, both heads SHALL pop in the same cycle and be compared for bitwise equality.
REQ-021 Compare results are registered: a pair pushed on the edge ending cycle t (both FIFOs previously empty) updates outputs on the edge ending cycle t+1.
REQ-022 Equal pair: cmp_cnt_o increments, saturating at 2^CNT_W-1.
REQ-023 Unequal pair: fail_idx_o <= cmp_cnt_o, ctr_equiv_o <= 0, mismatch_o pulses for 1 cycle, state -> FAIL.
REQ-024 A push to a full FIFO is accepted only if that FIFO pops in the same cycle; otherwise overflow_o <= 1, ctr_equiv_o <= 0, the push is dropped, and state -> OVF.
REQ-025 Overflow detection has priority over a same-cycle mismatch; both flags may set in the same cycle.
REQ-026 States: RUN, FAIL, OVF; FAIL and OVF are absorbing until clear_i or reset; in them pushes, pops and counters are frozen.
REQ-027 clear_i: flush both FIFOs, state -> RUN, ctr_equiv_o=1, all other outputs 0; clear_i overrides same-cycle retires, which are dropped.
REQ-028 Pointers are log2(DEPTH)+1 bits; full/empty are derived from the wrap bit; wrap-around is transparent.

Reset
REQ-029 While rst_ni=0: state RUN, FIFOs empty, ctr_equiv_o=1, mismatch_o=0, overflow_o=0, fail_idx_o=0, cmp_cnt_o=0, pending_o=0.
REQ-030 Reset asserted mid-compare SHALL discard the in-flight pair with no output pulse.

Structure
REQ-031 Package ctr_pkg holds the state enum (RUN, FAIL, OVF) and the default OBS_W, DEPTH and CNT_W constants.
REQ-032 Sub-module ctr_obs_fifo (synchronous FIFO, parametrised width/depth, push/pop/full/empty) SHALL be instantiated once per trace.
REQ-033 Trace count is fixed at two.

Verification
Bench parameters: OBS_W=8, DEPTH=4, mask=0xFF.
REQ-034 Same-cycle retires obs 0x11/0x11, then 0x22/0x22 -> cmp_cnt_o=2, ctr_equiv_o=1, pending_o=0.
REQ-035 Trace 1 retires 0xA1,0xA2,0xA3; trace 2 later retires 0xA1,0xA2,0xA3 -> no mismatch, cmp_cnt_o=3.
REQ-036 Pairs 0x05/0x05, 0x06/0x07 -> mismatch_o pulses once, fail_idx_o=1, ctr_equiv_o=0; later retires leave cmp_cnt_o=1.
REQ-037 mask=0x0F, obs 0x35/0xC5 -> equal, ctr_equiv_o stays 1.
REQ-038 Five trace-1 retires, no trace-2 retires -> overflow_o=1 on the fifth, ctr_equiv_o=0; clear_i restores ctr_equiv_o=1 and zeros all other outputs.
REQ-039 Reset asserted the cycle after a mismatching same-cycle pair -> no mismatch_o pulse, all outputs at reset values.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared definitions for the contract observation checker.
//   state_e         : checker state (RUN, FAIL, OVF)
//   *_DEF constants : default widths/depth used by ctr_obs_checker
//   NUM_TRACES      : number of compared traces (fixed at two)
package ctr_pkg;

  localparam int OBS_W_DEF  = 128;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 32;
  localparam int NUM_TRACES = 2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    FAIL = 2'd1,
    OVF  = 2'd2
  } state_e;

endpackage

// File: rtl/ctr_obs_fifo.sv
// Synchronous FIFO holding masked observations of one trace.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : synchronous empty (wins over push/pop)
//   push_i/data_i : write one entry (caller guarantees !full or same-cycle pop)
//   pop_i         : drop head entry (caller guarantees !empty)
//   data_o        : current head entry
//   full_o/empty_o: occupancy flags
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter.
module ctr_obs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem[rd_q[AW-1:0]];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/ctr_obs_checker.sv
// Compares two independently retiring observation traces pairwise.
//   clk_i, rst_ni         : clock, async active-low reset
//   retire_k_i / obs_k_i  : trace k retirement strobe and observation
//   mask_i                : observed-bit select, applied at push time
//   clear_i               : synchronous restart (flush, back to RUN)
//   ctr_equiv_o           : sticky "all pairs equal, no overflow"
//   mismatch_o            : one-cycle pulse on first unequal pair
//   overflow_o            : sticky overflow flag
//   fail_idx_o            : 0-based index of first unequal pair
//   cmp_cnt_o             : saturating count of equal pairs compared
//   pending_o             : either trace FIFO holds entries
// Heads are compared in the cycle they pop; the result lands in the output
// registers at that edge, so an async reset before the edge discards it.
module ctr_obs_checker
  import ctr_pkg::*;
#(
  parameter int OBS_W = OBS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             retire_1_i,
  input  logic [OBS_W-1:0] obs_1_i,
  input  logic             retire_2_i,
  input  logic [OBS_W-1:0] obs_2_i,
  input  logic [OBS_W-1:0] mask_i,
  input  logic             clear_i,
  output logic             ctr_equiv_o,
  output logic             mismatch_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] fail_idx_o,
  output logic [CNT_W-1:0] cmp_cnt_o,
  output logic             pending_o
);

  state_e state_q, state_d;

  logic [NUM_TRACES-1:0]            retire, push, drop, full, empty;
  logic [NUM_TRACES-1:0][OBS_W-1:0] obs, head;
  logic                             run, pop;

  logic             equiv_d, mis_d, ovf_d;
  logic [CNT_W-1:0] fidx_d, cnt_d;

  assign retire = {retire_2_i, retire_1_i};
  assign obs    = {obs_2_i, obs_1_i};

  // Both heads leave together; a full FIFO that pops this cycle has room.
  assign run = (state_q == RUN) && !clear_i;
  assign pop = run && (empty == '0);

  for (genvar k = 0; k < NUM_TRACES; k++) begin : g_trace
    assign push[k] = run && retire[k] && (!full[k] || pop);
    assign drop[k] = run && retire[k] && full[k] && !pop;

    ctr_obs_fifo #(
      .W     (OBS_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (clear_i),
      .push_i  (push[k]),
      .data_i  (obs[k] & mask_i),
      .pop_i   (pop),
      .data_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k])
    );
  end

  assign pending_o = (empty != '1);

  always_comb begin
    state_d = state_q;
    equiv_d = ctr_equiv_o;
    mis_d   = 1'b0;
    ovf_d   = overflow_o;
    fidx_d  = fail_idx_o;
    cnt_d   = cmp_cnt_o;
    if (clear_i) begin
      state_d = RUN;
      equiv_d = 1'b1;
      ovf_d   = 1'b0;
      fidx_d  = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      if (pop) begin
        if (head[0] != head[1]) begin
          fidx_d  = cmp_cnt_o;
          equiv_d = 1'b0;
          mis_d   = 1'b1;
          state_d = FAIL;
        end else if (cmp_cnt_o != '1) begin
          cnt_d = cmp_cnt_o + 1'b1;
        end
      end
      // Later assignment gives overflow the final say on the state.
      if (drop != '0) begin
        ovf_d   = 1'b1;
        equiv_d = 1'b0;
        state_d = OVF;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      ctr_equiv_o <= 1'b1;
      mismatch_o  <= 1'b0;
      overflow_o  <= 1'b0;
      fail_idx_o  <= '0;
      cmp_cnt_o   <= '0;
    end else begin
      state_q     <= state_d;
      ctr_equiv_o <= equiv_d;
      mismatch_o  <= mis_d;
      overflow_o  <= ovf_d;
      fail_idx_o  <= fidx_d;
      cmp_cnt_o   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ctr_obs_checker.sv
module tb_ctr_obs_checker;

  localparam int OW = 8;
  localparam int DP = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r1 = 1'b0, r2 = 1'b0, clr = 1'b0;
  logic [OW-1:0] o1 = '0, o2 = '0, mask = 8'hFF;
  logic          equiv, mis, ovf, pend;
  logic [CW-1:0] fidx, cnt;

  int n_chk = 0;
  int n_err = 0;

  ctr_obs_checker #(.OBS_W(OW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .retire_1_i  (r1),
    .obs_1_i     (o1),
    .retire_2_i  (r2),
    .obs_2_i     (o2),
    .mask_i      (mask),
    .clear_i     (clr),
    .ctr_equiv_o (equiv),
    .mismatch_o  (mis),
    .overflow_o  (ovf),
    .fail_idx_o  (fidx),
    .cmp_cnt_o   (cnt),
    .pending_o   (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r1, r2, clr;
    logic [OW-1:0] o1, o2, mask;
    logic          eq, mis, ovf, pend;
    logic [CW-1:0] fidx, cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r1_, logic [7:0] o1_, logic r2_, logic [7:0] o2_,
                              logic [7:0] m_, logic c_, logic eq_, logic mi_, logic ov_,
                              logic [7:0] fi_, logic [7:0] cn_, logic pe_);
    vec_t v;
    v.r1 = r1_; v.o1 = o1_; v.r2 = r2_; v.o2 = o2_; v.mask = m_; v.clr = c_;
    v.eq = eq_; v.mis = mi_; v.ovf = ov_; v.fidx = fi_; v.cnt = cn_; v.pend = pe_;
    return v;
  endfunction

  // outputs packed as {equiv, mismatch, overflow, fail_idx, cmp_cnt, pending}
  function automatic logic [19:0] pack(logic e, logic m, logic o, logic [7:0] f,
                                       logic [7:0] c, logic p);
    return {e, m, o, f, c, p};
  endfunction

  task automatic chk(input string nm, input logic [19:0] exp);
    logic [19:0] act;
    act = pack(equiv, mis, ovf, fidx, cnt, pend);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got eq=%b mis=%b ovf=%b fidx=%0d cnt=%0d pend=%b, want eq=%b mis=%b ovf=%b fidx=%0d cnt=%0d pend=%b",
               nm, act[19], act[18], act[17], act[16:9], act[8:1], act[0],
               exp[19], exp[18], exp[17], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [7:0] x, input logic b,
                       input logic [7:0] y, input logic [7:0] m, input logic c);
    r1 = a; o1 = x; r2 = b; o2 = y; mask = m; clr = c;
  endtask

  localparam logic [19:0] RST_OUT = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};

  // reference model state (plain queues and counters)
  logic [7:0] q1[$], q2[$];
  int         m_st;  // 0 running, 1 failed, 2 overflowed
  logic       m_eq, m_mis, m_ovf;
  logic [7:0] m_fidx;
  int         m_cnt;

  task automatic model_step(input logic a, input logic [7:0] x, input logic b,
                            input logic [7:0] y, input logic [7:0] m, input logic c);
    logic [7:0] h1, h2;
    m_mis = 1'b0;
    if (c) begin
      q1.delete(); q2.delete();
      m_st = 0; m_eq = 1'b1; m_ovf = 1'b0; m_fidx = '0; m_cnt = 0;
    end else if (m_st == 0) begin
      bit dropped = 0;
      if (q1.size() > 0 && q2.size() > 0) begin
        h1 = q1.pop_front();
        h2 = q2.pop_front();
        if (h1 != h2) begin
          m_fidx = 8'(m_cnt); m_eq = 1'b0; m_mis = 1'b1; m_st = 1;
        end else if (m_cnt < (1 << CW) - 1) begin
          m_cnt++;
        end
      end
      if (a) begin
        if (q1.size() < DP) q1.push_back(x & m); else dropped = 1;
      end
      if (b) begin
        if (q2.size() < DP) q2.push_back(y & m); else dropped = 1;
      end
      if (dropped) begin
        m_ovf = 1'b1; m_eq = 1'b0; m_st = 2;
      end
    end
  endtask

  initial begin
    // directed table: idle / clear shorthands use mask FF
    // same-cycle pairs
    tbl.push_back(mk(1,8'h11,1,8'h11,8'hFF,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,8'h22,1,8'h22,8'hFF,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         1,0,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         1,0,0,0,2,0));
    // trace 2 lags trace 1
    tbl.push_back(mk(0,0,0,0,8'hFF,1,         1,0,0,0,0,0));
    tbl.push_back(mk(1,8'hA1,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'hA2,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'hA3,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,8'hA1,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,8'hA2,8'hFF,0,     1,0,0,0,1,1));
    tbl.push_back(mk(0,0,1,8'hA3,8'hFF,0,     1,0,0,0,2,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         1,0,0,0,3,0));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         1,0,0,0,3,0));
    // mismatch on second pair, then frozen
    tbl.push_back(mk(0,0,0,0,8'hFF,1,         1,0,0,0,0,0));
    tbl.push_back(mk(1,8'h05,1,8'h05,8'hFF,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,8'h06,1,8'h07,8'hFF,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         0,1,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         0,0,0,1,1,0));
    tbl.push_back(mk(1,8'h09,1,8'h09,8'hFF,0, 0,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         0,0,0,1,1,0));
    // mask applied at push
    tbl.push_back(mk(0,0,0,0,8'hFF,1,         1,0,0,0,0,0));
    tbl.push_back(mk(1,8'h35,1,8'hC5,8'h0F,0, 1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         1,0,0,0,1,0));
    // overflow on fifth unmatched push, then clear
    tbl.push_back(mk(0,0,0,0,8'hFF,1,         1,0,0,0,0,0));
    tbl.push_back(mk(1,8'h01,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'h02,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'h03,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'h04,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'h05,0,0,8'hFF,0,     0,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         0,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,1,         1,0,0,0,0,0));
    // push into full FIFO accepted when it pops the same cycle; pointer wrap
    tbl.push_back(mk(1,8'hB0,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'hB1,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'hB2,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'hB3,0,0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,8'hB0,8'hFF,0,     1,0,0,0,0,1));
    tbl.push_back(mk(1,8'hB4,1,8'hB1,8'hFF,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,0,1,8'hB2,8'hFF,0,     1,0,0,0,2,1));
    tbl.push_back(mk(0,0,1,8'hB3,8'hFF,0,     1,0,0,0,3,1));
    tbl.push_back(mk(0,0,1,8'hB4,8'hFF,0,     1,0,0,0,4,1));
    tbl.push_back(mk(0,0,0,0,8'hFF,0,         1,0,0,0,5,0));

    // reset state
    tick(); tick();
    chk("reset_hold", RST_OUT);
    rst_n = 1'b1;
    tick();
    chk("reset_release", RST_OUT);

    foreach (tbl[i]) begin
      drive(tbl[i].r1, tbl[i].o1, tbl[i].r2, tbl[i].o2, tbl[i].mask, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d", i),
          pack(tbl[i].eq, tbl[i].mis, tbl[i].ovf, tbl[i].fidx, tbl[i].cnt, tbl[i].pend));
    end

    // reset lands while a mismatching pair is being compared
    drive(0, 0, 0, 0, 8'hFF, 1); tick();
    drive(1, 8'h05, 1, 8'h06, 8'hFF, 0); tick();
    drive(0, 0, 0, 0, 8'hFF, 0);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_compare", RST_OUT);
    rst_n = 1'b1;
    tick();
    chk("rst_pair_gone", RST_OUT);

    // counter saturation
    drive(0, 0, 0, 0, 8'hFF, 1); tick();
    drive(1, 8'h77, 1, 8'h77, 8'hFF, 0);
    repeat (258) tick();
    drive(0, 0, 0, 0, 8'hFF, 0);
    tick(); tick();
    chk("cnt_saturate", pack(1'b1, 1'b0, 1'b0, 8'd0, 8'hFF, 1'b0));

    // randomized run against the queue model
    for (int i = 0; i < 600; i++) begin
      logic       a, b, c;
      logic [7:0] x, y, m;
      logic [7:0] masks [4];
      masks[0] = 8'hFF; masks[1] = 8'h0F; masks[2] = 8'hF0; masks[3] = 8'h03;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      c = (i == 0) || ($urandom_range(0, 11) == 0);
      x = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h3C;
      y = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h3C;
      m = masks[$urandom_range(0, 3)];
      drive(a, x, b, y, m, c);
      model_step(a, x, b, y, m, c);
      tick();
      chk($sformatf("rand%0d", i),
          pack(m_eq, m_mis, m_ovf, m_fidx, 8'(m_cnt), (q1.size() > 0) || (q2.size() > 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
